// File: rtl/fadd_share_arb_if.sv
// Requester-side handshake bundle for the shared adder arbiter:
// operand requests in, per-requester results out.
interface fadd_share_arb_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_sub;
  logic [32*NREQ-1:0]   req_x1;
  logic [32*NREQ-1:0]   req_x2;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [32*NREQ-1:0]   resp_y;
  logic [NREQ-1:0]      resp_ready;

  modport master (
    output req_valid, req_sub, req_x1, req_x2, resp_ready,
    input  req_ready, resp_valid, resp_y
  );

  modport slave (
    input  req_valid, req_sub, req_x1, req_x2, resp_ready,
    output req_ready, resp_valid, resp_y
  );
endinterface

// File: rtl/fadd_share_arb.sv
// Round-robin sharing of one pipelined FP adder between NREQ requesters,
// with owner tags tracked alongside the adder and per-requester result holding.
module fadd_share_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 3,
  parameter int unsigned IDW  = 2
) (
  input  logic                clk,
  input  logic                rstn,
  fadd_share_arb_if.slave     bus,
  output logic                fu_valid,
  output logic [31:0]         fu_x1,
  output logic [31:0]         fu_x2,
  input  logic [31:0]         fu_y,
  output logic                idle
);

  logic [NREQ-1:0]    busy_q, busy_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]    eligible, grant;
  logic               gnt_any;
  logic [IDW-1:0]     gnt_id;
  logic [31:0]        sel_x2;

  logic               fu_valid_q, fu_valid_d;
  logic [31:0]        fu_x1_q, fu_x1_d;
  logic [31:0]        fu_x2_q, fu_x2_d;
  logic [IDW-1:0]     fu_id_q, fu_id_d;

  logic [LAT-1:0]     tag_v_q, tag_v_d;
  logic [IDW-1:0]     tag_id_q [LAT];
  logic [IDW-1:0]     tag_id_d [LAT];

  logic [NREQ-1:0]    resp_valid_q, resp_valid_d;
  logic [32*NREQ-1:0] resp_y_q, resp_y_d;

  // Search eligible requesters starting at the pointer, wrapping around.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    eligible = bus.req_valid & ~busy_q;
    gnt_any  = 1'b0;
    gnt_id   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!gnt_any && eligible[IDW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
    grant = '0;
    // Grant is masked during reset so no handshake is offered while flops are held.
    if (gnt_any && rstn) grant[gnt_id] = 1'b1;
  end

  always_comb begin
    busy_d     = (busy_q | grant) & ~(resp_valid_q & bus.resp_ready);
    ptr_d      = ptr_q;
    fu_valid_d = 1'b0;
    fu_x1_d    = fu_x1_q;
    fu_x2_d    = fu_x2_q;
    fu_id_d    = fu_id_q;
    sel_x2     = bus.req_x2[32'(gnt_id)*32 +: 32];
    if (|grant) begin
      ptr_d      = IDW'((32'(gnt_id) + 32'd1) % NREQ);
      fu_valid_d = 1'b1;
      fu_id_d    = gnt_id;
      fu_x1_d    = bus.req_x1[32'(gnt_id)*32 +: 32];
      fu_x2_d    = {sel_x2[31] ^ bus.req_sub[gnt_id], sel_x2[30:0]};
    end

    // The fu register acts as tag stage zero, so the last stage lines up with fu_y.
    tag_v_d     = '0;
    tag_v_d[0]  = fu_valid_q;
    tag_id_d[0] = fu_id_q;
    for (int unsigned k = 1; k < LAT; k++) begin
      tag_v_d[k]  = tag_v_q[k-1];
      tag_id_d[k] = tag_id_q[k-1];
    end

    resp_valid_d = resp_valid_q & ~bus.resp_ready;
    resp_y_d     = resp_y_q;
    if (tag_v_q[LAT-1]) begin
      resp_valid_d[tag_id_q[LAT-1]]              = 1'b1;
      resp_y_d[32'(tag_id_q[LAT-1])*32 +: 32]    = fu_y;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q       <= '0;
      ptr_q        <= '0;
      fu_valid_q   <= 1'b0;
      fu_x1_q      <= '0;
      fu_x2_q      <= '0;
      fu_id_q      <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '{default: '0};
      resp_valid_q <= '0;
      resp_y_q     <= '0;
    end else begin
      busy_q       <= busy_d;
      ptr_q        <= ptr_d;
      fu_valid_q   <= fu_valid_d;
      fu_x1_q      <= fu_x1_d;
      fu_x2_q      <= fu_x2_d;
      fu_id_q      <= fu_id_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      resp_valid_q <= resp_valid_d;
      resp_y_q     <= resp_y_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_y     = resp_y_q;
  assign fu_valid       = fu_valid_q;
  assign fu_x1          = fu_x1_q;
  assign fu_x2          = fu_x2_q;
  assign idle           = ~|busy_q;

endmodule

// File: tb/tb_fadd_share_arb.sv
// Directed bench for fadd_share_arb: vector table of single ops plus
// hand sequences for round robin, back-pressure, pointer wrap and reset.
`timescale 1ns/1ps
module tb_fadd_share_arb;
  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 3;
  localparam int unsigned IDW  = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fadd_share_arb_if #(.NREQ(NREQ)) bus ();
  logic        fu_valid;
  logic [31:0] fu_x1, fu_x2, fu_y;
  logic        idle;

  fadd_share_arb #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .fu_valid(fu_valid), .fu_x1(fu_x1), .fu_x2(fu_x2), .fu_y(fu_y), .idle(idle)
  );

  // Stand-in adder: exact results for the known float pairs, XOR otherwise.
  function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
    return a ^ b;
  endfunction

  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fu_valid ? fake_add(fu_x1, fu_x2) : 32'hBAD0BAD0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fu_y = pipe[LAT-1];

  for (genvar g = 0; g < NREQ; g++) begin : g_clr
    a_no_recapture: assert property (@(posedge clk) disable iff (!rstn)
      (bus.resp_valid[g] && bus.resp_ready[g]) |=> !bus.resp_valid[g]);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < 30) begin
      @(negedge clk); #1; n++;
    end
    chk(name, idle, 1'b1);
  endtask

  typedef struct {
    int          id;
    logic        sub;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] fx2;
    logic [31:0] y;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [3:0] exp_rdy;
    vecs[0] = '{0, 1'b0, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000};
    vecs[1] = '{2, 1'b1, 32'h40400000, 32'h3F800000, 32'hBF800000, 32'h40000000};
    vecs[2] = '{1, 1'b1, 32'h7FC00001, 32'h00000001, 32'h80000001, 32'hFFC00000};
    vecs[3] = '{3, 1'b0, 32'h12345678, 32'h00FF00FF, 32'h00FF00FF, 32'h12CB5687};
    vecs[4] = '{3, 1'b1, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000};

    // Reset with every requester asking: nothing may be granted.
    bus.req_valid  = '1;
    bus.req_sub    = '0;
    bus.resp_ready = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_x1[32*i +: 32] = 32'h10000000 * (i + 1);
      bus.req_x2[32*i +: 32] = i;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 4'b0);
    chk("rst_fu_valid", fu_valid, 1'b0);
    chk("rst_fu_x", {fu_x1, fu_x2}, 64'h0);
    chk("rst_resp_valid", bus.resp_valid, 4'b0);
    chk("rst_resp_y", bus.resp_y, 128'h0);
    chk("rst_idle", idle, 1'b1);

    // Round robin from reset release: grants 0..3, responses 5..8.
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) step();
      #1;
      chk($sformatf("rr_ready_c%0d", c), bus.req_ready, (c < 4) ? (4'b1 << c) : 4'b0);
      chk($sformatf("rr_fu_valid_c%0d", c), fu_valid, (c >= 1 && c <= 4));
      chk($sformatf("rr_resp_valid_c%0d", c), bus.resp_valid,
          (c >= 5) ? ((4'b1 << (c - 4)) - 4'b1) : 4'b0);
      if (c == 1) chk("rr_fu_x1_c1", fu_x1, 32'h10000000);
      if (c == 2) chk("rr_fu_x2_c2", fu_x2, 32'h00000001);
    end
    chk("rr_resp_y", bus.resp_y, 128'h40000003_30000002_20000001_10000000);

    // Back-pressure on requester 1 while 0 and 2 keep issuing (still cycle 8).
    bus.resp_ready = 4'b1101;
    bus.req_valid  = 4'b0111;
    for (int c = 9; c <= 22; c++) begin
      step();
      if (c == 21) bus.resp_ready = 4'b1111;
      #1;
      case (c)
        9, 15, 21: exp_rdy = 4'b0001;
        10, 16:    exp_rdy = 4'b0100;
        22:        exp_rdy = 4'b0010;
        default:   exp_rdy = 4'b0000;
      endcase
      chk($sformatf("bp_ready_c%0d", c), bus.req_ready, exp_rdy);
      if (c <= 21)
        chk($sformatf("bp_hold1_c%0d", c), {bus.resp_valid[1], bus.resp_y[63:32]},
            {1'b1, 32'h20000001});
    end
    step();
    bus.req_valid  = '0;
    bus.resp_ready = '1;
    drain("bp_drain");

    // Pointer wrap: move pointer to 3, then only 0 and 3 request.
    step(); bus.req_valid = 4'b0100; #1;
    chk("wrap_setup", bus.req_ready, 4'b0100);
    step(); bus.req_valid = '0;
    drain("wrap_drain0");
    step(); bus.req_valid = 4'b1001; #1;
    chk("wrap_grant3", bus.req_ready, 4'b1000);
    step(); #1;
    chk("wrap_grant0", bus.req_ready, 4'b0001);
    step(); bus.req_valid = '0;
    drain("wrap_drain1");
    step(); bus.req_valid = 4'b0011; #1;
    chk("wrap_ptr1", bus.req_ready, 4'b0010);
    step(); bus.req_valid = '0;
    drain("wrap_drain2");

    // Single-op vectors.
    foreach (vecs[v]) begin
      step();
      bus.resp_ready = '0;
      bus.req_valid  = 4'b1 << vecs[v].id;
      bus.req_sub[vecs[v].id] = vecs[v].sub;
      bus.req_x1[32*vecs[v].id +: 32] = vecs[v].x1;
      bus.req_x2[32*vecs[v].id +: 32] = vecs[v].x2;
      #1;
      chk($sformatf("v%0d_ready", v), bus.req_ready, 4'b1 << vecs[v].id);
      step(); bus.req_valid = '0; #1;
      chk($sformatf("v%0d_fu", v), {fu_valid, fu_x1, fu_x2}, {1'b1, vecs[v].x1, vecs[v].fx2});
      repeat (3) step();
      #1;
      chk($sformatf("v%0d_early", v), {bus.resp_valid, idle}, {4'b0, 1'b0});
      step(); #1;
      chk($sformatf("v%0d_resp", v), {bus.resp_valid, bus.resp_y[32*vecs[v].id +: 32], idle},
          {4'b1 << vecs[v].id, vecs[v].y, 1'b0});
      step(); #1;
      chk($sformatf("v%0d_hold", v), {bus.resp_valid, bus.resp_y[32*vecs[v].id +: 32]},
          {4'b1 << vecs[v].id, vecs[v].y});
      bus.resp_ready = 4'b1 << vecs[v].id;
      step(); #1;
      chk($sformatf("v%0d_done", v), {bus.resp_valid, idle}, {4'b0, 1'b1});
      bus.req_sub = '0;
    end

    // Reset two cycles after three issues; stale fu_y must be ignored.
    step();
    bus.resp_ready = '0;
    bus.req_valid  = 4'b0111;
    repeat (2) step();
    step(); bus.req_valid = '0; #1;
    chk("mr_busy", idle, 1'b0);
    step();
    rstn = 1'b0;
    bus.req_valid = '1;
    #1;
    chk("mr_req_ready", bus.req_ready, 4'b0);
    chk("mr_fu", {fu_valid, fu_x1, fu_x2}, 65'h0);
    chk("mr_resp", {bus.resp_valid, bus.resp_y}, 132'h0);
    chk("mr_idle", idle, 1'b1);
    step();
    bus.req_valid = '0;
    rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("mr_stale_c%0d", c), bus.resp_valid, 4'b0);
      step();
    end
    #1;
    chk("mr_idle_end", idle, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fadd_share_arb.md
Name: fadd_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined single-precision adder between NREQ requesters (e.g. issue lanes or the FPU dispatch ports).
- Accepts operand pairs with valid/ready handshakes and optionally negates x2 so the adder also performs subtraction.
- Tracks each in-flight operation's owner with a tag pipeline matched to the adder latency.
- Returns each result to its owner through a per-requester result register with valid/ready.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 3, adder latency in cycles from fu_valid/fu_x* to the matching fu_y (>=1).
- IDW, 2, width of requester index; must equal clog2(NREQ).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request present, one bit per requester
- req_sub  in  NREQ  1 = compute x1 - x2
- req_x1  in  32*NREQ  operand 1, requester i at [32i+31:32i]
- req_x2  in  32*NREQ  operand 2, same packing
- req_ready  out  NREQ  grant; at most one bit high (one-hot or zero)
- fu_valid  out  1  operands presented to adder this cycle (registered)
- fu_x1  out  32  operand 1 to adder (registered)
- fu_x2  out  32  operand 2 to adder, sign already flipped for sub (registered)
- fu_y  in  32  adder result, valid LAT cycles after the matching fu_valid
- resp_valid  out  NREQ  result available for requester i
- resp_y  out  32*NREQ  result for requester i, same packing
- resp_ready  in  NREQ  requester i consumes result
- idle  out  1  no operation pending anywhere (all busy bits clear)

Behaviour:
- Reset (rstn low, async):
  - req_ready=0, fu_valid=0, fu_x1=fu_x2=0, resp_valid=0, resp_y=0, idle=1.
  - Round-robin pointer=0, all busy bits=0, tag pipeline cleared.
  - Reset mid-operation discards in-flight ops; fu_y returning after reset is ignored.
- busy[i]:
  - Set on the req handshake of requester i.
  - Cleared on resp_valid[i] && resp_ready[i].
  - Each requester has at most one op in flight or held.
- Eligibility: eligible[i] = req_valid[i] && !busy[i], using the registered busy value.
  - A requester whose response is consumed in cycle c can be granted no earlier than cycle c+1.
- Arbitration (combinational, every cycle):
  - Search eligible from pointer upward with wrap-around; the first hit i gets req_ready[i]=1.
  - req_ready is never asserted to a non-valid or busy requester.
- Pointer: after a grant to i, pointer <= (i+1) mod NREQ; unchanged when no grant.
- Issue, on the handshake in cycle c:
  - fu_x1 <= req_x1[i].
  - fu_x2 <= {req_x2[i][31]^req_sub[i], req_x2[i][30:0]}.
  - fu_valid <= 1 in cycle c+1, otherwise 0.
  - Throughput: one issue per cycle.
  - fu_x1/fu_x2 hold their last values while fu_valid=0.
- Tag pipeline: LAT-deep shift register of {valid, id}.
  - Stage 0 is loaded alongside fu_valid.
  - When the last stage is valid in cycle c+1+LAT, fu_y is captured into resp_y[id] and resp_valid[id] <= 1.
- Latency: handshake in cycle c gives resp_valid high from cycle c+2+LAT (LAT=3: cycle c+5).
- Response:
  - resp_valid[i] and resp_y[i] hold stable until resp_ready[i].
  - Clearing and capture for the same i cannot coincide (busy rule). Assert this in the bench.
  - Responses to different requesters are independent; multiple can complete in any order.
- idle = ~|busy.
- The adder arithmetic is external. This block never modifies fu_y and is value-agnostic (NaN/denormal pass through).

Test Plan:
- Single op: req0 x1=0x3F800000 (1.0), x2=0x40000000 (2.0), sub=0, handshake cycle 0 -> fu_valid cycle 1 with fu_x2=0x40000000; resp_valid[0] cycle 5 with resp_y[0]=0x40400000 (3.0); idle=0 until resp_ready[0] accepted, then 1.
- Subtract: req2 x1=0x40400000, x2=0x3F800000, sub=1 -> fu_x2=0xBF800000; resp_y[2]=0x40000000.
- Round robin: all four req_valid high from reset release -> grants 0,1,2,3 in consecutive cycles; fu_valid high 4 cycles; resp_valid[0..3] rise on cycles 5,6,7,8.
- Back-pressure: resp_ready[1]=0 with req1 reissuing continuously -> resp_y[1] held; req1 never granted; req0/req2 granted alternately. Raise resp_ready[1] in cycle k -> req1 eligible in cycle k+1.
- Pointer wrap: pointer=3, only req0 and req3 valid -> grant 3, then 0; pointer=1 afterwards.
- Reset mid-flight: assert rstn=0 two cycles after three issues -> all outputs 0 immediately; stale fu_y after release produces no resp_valid; idle=1.
